// File: rtl/decode_issue_if.sv
// Decode/issue bus: instruction in, regfile read, writeback bypass,
// issued operation out. slave = decode_issue, master = its environment.
interface decode_issue_if;
  logic [31:0] inst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] D0;
  logic [31:0] D1;
  logic [5:0]  OpCode;
  logic [4:0]  dst;
  logic        out_valid;
  logic        out_ready;
  logic        alu_error;
  logic        illegal;

  modport slave (
    input  inst, in_valid, ra_data, rb_data,
    input  wb_en, wb_addr, wb_data,
    input  out_ready, alu_error,
    output in_ready, ra_addr, rb_addr,
    output D0, D1, OpCode, dst,
    output out_valid, illegal
  );

  modport master (
    output inst, in_valid, ra_data, rb_data,
    output wb_en, wb_addr, wb_data,
    output out_ready, alu_error,
    input  in_ready, ra_addr, rb_addr,
    input  D0, D1, OpCode, dst,
    input  out_valid, illegal
  );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes R/I-type words, selects operands
// (zero reg, wb bypass, regfile) and issues them through one output slot.
// Ports: clk, rst (async, active-high), bus (decode_issue_if.slave).
module decode_issue (
  input  logic clk,
  input  logic rst,
  decode_issue_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    K_ILL,
    K_R,
    K_SEXT,
    K_ZEXT
  } kind_t;

  state_t state;

  logic [31:0] d0_q;
  logic [31:0] d1_q;
  logic [5:0]  op_q;
  logic [4:0]  dst_q;
  logic        ill_q;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;

  assign op    = bus.inst[31:26];
  assign rs    = bus.inst[25:21];
  assign rt    = bus.inst[20:16];
  assign rd    = bus.inst[15:11];
  assign imm   = bus.inst[15:0];
  assign funct = bus.inst[5:0];

  logic r_ok;
  logic s_ok;
  logic z_ok;

  always_comb begin
    r_ok = 1'b0;
    if (op == 6'h00) begin
      unique case (funct)
        6'h08, 6'h09, 6'h04, 6'h05,
        6'h06, 6'h07, 6'h26, 6'h27,
        6'h0c, 6'h0d, 6'h2c, 6'h2d,
        6'h20, 6'h21, 6'h10, 6'h30,
        6'h38, 6'h24, 6'h03, 6'h02:
          r_ok = 1'b1;
        default: r_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    s_ok = 1'b0;
    z_ok = 1'b0;
    unique case (op)
      6'h08, 6'h09, 6'h2c, 6'h2d: s_ok = 1'b1;
      6'h20, 6'h30, 6'h38, 6'h3c: z_ok = 1'b1;
      default: ;
    endcase
  end

  kind_t kind;

  always_comb begin
    kind = K_ILL;
    unique case (1'b1)
      r_ok:    kind = K_R;
      s_ok:    kind = K_SEXT;
      z_ok:    kind = K_ZEXT;
      default: kind = K_ILL;
    endcase
  end

  // r0 reads as zero even if a writeback targets it
  function automatic logic [31:0] pick(
    input logic [4:0]  a,
    input logic [31:0] rf,
    input logic        en,
    input logic [4:0]  wa,
    input logic [31:0] wd
  );
    if (a == 5'd0)
      return 32'd0;
    else if (en && wa == a)
      return wd;
    else
      return rf;
  endfunction

  logic [31:0] opa;
  logic [31:0] opb;

  assign opa = pick(rs, bus.ra_data, bus.wb_en,
                    bus.wb_addr, bus.wb_data);
  assign opb = pick(rt, bus.rb_data, bus.wb_en,
                    bus.wb_addr, bus.wb_data);

  logic [31:0] nx_d0;
  logic [31:0] nx_d1;
  logic [5:0]  nx_op;
  logic [4:0]  nx_dst;

  always_comb begin
    nx_d0  = 32'd0;
    nx_d1  = 32'd0;
    nx_op  = 6'd0;
    nx_dst = 5'd0;
    unique case (kind)
      K_R: begin
        nx_op  = funct;
        nx_d0  = opa;
        nx_d1  = opb;
        nx_dst = rd;
      end
      K_SEXT: begin
        nx_op  = op;
        nx_d0  = opa;
        nx_d1  = {{16{imm[15]}}, imm};
        nx_dst = rt;
      end
      K_ZEXT: begin
        nx_op  = op;
        nx_d0  = opa;
        nx_d1  = {16'h0000, imm};
        nx_dst = rt;
      end
      default: ;
    endcase
  end

  logic full;
  logic accept;

  assign full   = (state == FULL);
  assign accept = bus.in_valid & bus.in_ready;

  assign bus.in_ready =
    (~full | bus.out_ready) & ~bus.alu_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      d0_q  <= 32'd0;
      d1_q  <= 32'd0;
      op_q  <= 6'd0;
      dst_q <= 5'd0;
      ill_q <= 1'b0;
    end else begin
      ill_q <= 1'b0;
      if (bus.alu_error) begin
        // flush wins over accept, drain and hold
        state <= EMPTY;
        d0_q  <= 32'd0;
        d1_q  <= 32'd0;
        op_q  <= 6'd0;
        dst_q <= 5'd0;
      end else if (accept) begin
        state <= FULL;
        d0_q  <= nx_d0;
        d1_q  <= nx_d1;
        op_q  <= nx_op;
        dst_q <= nx_dst;
        ill_q <= (kind == K_ILL);
      end else if (full && bus.out_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.ra_addr   = rs;
  assign bus.rb_addr   = rt;
  assign bus.D0        = d0_q;
  assign bus.D1        = d1_q;
  assign bus.OpCode    = op_q;
  assign bus.dst       = dst_q;
  assign bus.out_valid = full;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed vector table, corner sequences,
// and random traffic against a behavioural model.
module tb_decode_issue;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  decode_issue_if bus ();

  decode_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  int legal_r[20] = '{
    'h08, 'h09, 'h04, 'h05, 'h06,
    'h07, 'h26, 'h27, 'h0c, 'h0d,
    'h2c, 'h2d, 'h20, 'h21, 'h10,
    'h30, 'h38, 'h24, 'h03, 'h02
  };
  int sext_ops[4] = '{'h08, 'h09, 'h2c, 'h2d};
  int zext_ops[4] = '{'h20, 'h30, 'h38, 'h3c};

  // 0 illegal, 1 R, 2 I sign-ext, 3 I zero-ext
  function automatic int kind_of(input logic [31:0] w);
    int o;
    int f;
    o = int'(w[31:26]);
    f = int'(w[5:0]);
    if (o == 0) begin
      for (int i = 0; i < 20; i++)
        if (legal_r[i] == f) return 1;
      return 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (sext_ops[i] == o) return 2;
      if (zext_ops[i] == o) return 3;
    end
    return 0;
  endfunction

  function automatic logic [31:0] operand(
    input logic [4:0] a, input logic [31:0] rf,
    input logic en, input logic [4:0] wa,
    input logic [31:0] wd);
    if (a == 0) return 0;
    if (en && wa == a) return wd;
    return rf;
  endfunction

  function automatic logic [31:0] r_inst(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_inst(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  typedef struct {
    string       nm;
    logic [31:0] inst;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [5:0]  op;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [4:0]  dst;
    logic        ill;
  } vec_t;

  function automatic vec_t mk(
    input string nm, input logic [31:0] inst,
    input logic [31:0] ra, input logic [31:0] rb,
    input logic wen, input logic [4:0] wa,
    input logic [31:0] wd, input logic [5:0] op,
    input logic [31:0] d0, input logic [31:0] d1,
    input logic [4:0] dst, input logic ill);
    vec_t v;
    v.nm = nm; v.inst = inst;
    v.ra = ra; v.rb = rb;
    v.wen = wen; v.wa = wa; v.wd = wd;
    v.op = op; v.d0 = d0; v.d1 = d1;
    v.dst = dst; v.ill = ill;
    return v;
  endfunction

  vec_t tbl[12];

  // behavioural model of the output slot
  logic        m_v;
  logic [31:0] m_d0;
  logic [31:0] m_d1;
  logic [5:0]  m_op;
  logic [4:0]  m_dst;
  logic        m_ill;

  task automatic model_clear();
    m_v = 0; m_d0 = 0; m_d1 = 0;
    m_op = 0; m_dst = 0; m_ill = 0;
  endtask

  task automatic model_edge();
    logic rdy;
    logic [31:0] w;
    int k;
    rdy = (!m_v || bus.out_ready) && !bus.alu_error;
    m_ill = 0;
    w = bus.inst;
    if (bus.alu_error) begin
      model_clear();
    end else if (bus.in_valid && rdy) begin
      k = kind_of(w);
      m_v = 1;
      m_d0 = 0; m_d1 = 0; m_op = 0; m_dst = 0;
      if (k == 0) begin
        m_ill = 1;
      end else begin
        m_d0 = operand(w[25:21], bus.ra_data,
                       bus.wb_en, bus.wb_addr, bus.wb_data);
        if (k == 1) begin
          m_op  = w[5:0];
          m_dst = w[15:11];
          m_d1  = operand(w[20:16], bus.rb_data,
                          bus.wb_en, bus.wb_addr, bus.wb_data);
        end else begin
          m_op  = w[31:26];
          m_dst = w[20:16];
          m_d1  = (k == 2) ? 32'($signed(w[15:0]))
                           : 32'(w[15:0]);
        end
      end
    end else if (m_v && bus.out_ready) begin
      m_v = 0;
    end
  endtask

  function automatic logic [31:0] rand_inst();
    int s;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] fn;
    s  = $urandom_range(0, 9);
    rs = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    rt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    if (s < 5) begin
      fn = (s < 4) ? 6'(legal_r[$urandom_range(0, 19)])
                   : 6'($urandom);
      return {6'd0, rs, rt, 5'($urandom), 5'($urandom), fn};
    end
    if (s < 8) begin
      fn = (s < 7) ? 6'(sext_ops[$urandom_range(0, 3)])
                   : 6'(zext_ops[$urandom_range(0, 3)]);
      return {fn, rs, rt, 16'($urandom)};
    end
    return {6'($urandom), rs, rt, 16'($urandom)};
  endfunction

  task automatic drive(input vec_t v);
    bus.inst    = v.inst;
    bus.ra_data = v.ra;
    bus.rb_data = v.rb;
    bus.wb_en   = v.wen;
    bus.wb_addr = v.wa;
    bus.wb_data = v.wd;
  endtask

  task automatic check_slot(input string nm,
    input logic [5:0] op, input logic [31:0] d0,
    input logic [31:0] d1, input logic [4:0] dst);
    chk({nm, ".op"},  32'(bus.OpCode), 32'(op));
    chk({nm, ".d0"},  bus.D0, d0);
    chk({nm, ".d1"},  bus.D1, d1);
    chk({nm, ".dst"}, 32'(bus.dst), 32'(dst));
  endtask

  vec_t va;
  vec_t vb;

  initial begin
    tbl[0]  = mk("add", r_inst(3, 4, 5, 6'h08), 7, 9,
                 0, 0, 0, 6'h08, 7, 9, 5, 0);
    tbl[1]  = mk("addi", i_inst(6'h08, 1, 2, 16'hfffe),
                 32'h10, 55, 0, 0, 0,
                 6'h08, 32'h10, 32'hfffffffe, 2, 0);
    tbl[2]  = mk("ori", i_inst(6'h30, 1, 2, 16'hfffe),
                 32'h10, 55, 0, 0, 0,
                 6'h30, 32'h10, 32'h0000fffe, 2, 0);
    tbl[3]  = mk("lui", i_inst(6'h3c, 0, 7, 16'h1234),
                 99, 55, 0, 0, 0,
                 6'h3c, 0, 32'h00001234, 7, 0);
    tbl[4]  = mk("byp_a", r_inst(6, 7, 8, 6'h20), 1, 2,
                 1, 6, 32'ha5a5a5a5,
                 6'h20, 32'ha5a5a5a5, 2, 8, 0);
    tbl[5]  = mk("zero_a", i_inst(6'h09, 0, 3, 16'h0005),
                 32'hffffffff, 1, 0, 0, 0,
                 6'h09, 0, 5, 3, 0);
    tbl[6]  = mk("zero_wb", r_inst(0, 4, 9, 6'h24),
                 32'hffffffff, 3, 1, 0, 32'hdead,
                 6'h24, 0, 3, 9, 0);
    tbl[7]  = mk("byp_b", r_inst(2, 4, 1, 6'h03), 11, 3,
                 1, 4, 32'h12345678,
                 6'h03, 11, 32'h12345678, 1, 0);
    tbl[8]  = mk("ill_op", 32'h04432005, 5, 6,
                 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk("ill_fn", r_inst(1, 2, 3, 6'h3f), 5, 6,
                 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk("sltiu", i_inst(6'h2d, 5, 6, 16'h8000),
                 42, 0, 0, 0, 0,
                 6'h2d, 42, 32'hffff8000, 6, 0);
    tbl[11] = mk("xori", i_inst(6'h38, 31, 30, 16'h8001),
                 77, 0, 1, 31, 0,
                 6'h38, 0, 32'h00008001, 30, 0);

    va = tbl[0];
    vb = mk("b", i_inst(6'h08, 1, 2, 16'h0003), 100, 0,
            0, 0, 0, 6'h08, 100, 3, 2, 0);

    rst = 1;
    bus.inst = 0; bus.in_valid = 0;
    bus.ra_data = 0; bus.rb_data = 0;
    bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.out_ready = 0; bus.alu_error = 0;

    #1;
    chk("rst.valid", 32'(bus.out_valid), 0);
    chk("rst.ill", 32'(bus.illegal), 0);
    check_slot("rst", 0, 0, 0, 0);

    @(negedge clk); @(negedge clk);
    rst = 0;
    #1 chk("rst.rdy", 32'(bus.in_ready), 1);

    // vector table, each from an empty slot
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      bus.in_valid = 1; bus.out_ready = 1;
      #1 chk({tbl[i].nm, ".ra_addr"},
             32'(bus.ra_addr), 32'(tbl[i].inst[25:21]));
      @(posedge clk); #1;
      chk({tbl[i].nm, ".valid"}, 32'(bus.out_valid), 1);
      chk({tbl[i].nm, ".ill"}, 32'(bus.illegal),
          32'(tbl[i].ill));
      check_slot(tbl[i].nm, tbl[i].op, tbl[i].d0,
                 tbl[i].d1, tbl[i].dst);
      @(negedge clk);
      bus.in_valid = 0;
      @(posedge clk); #1;
      chk({tbl[i].nm, ".drain"}, 32'(bus.out_valid), 0);
      chk({tbl[i].nm, ".ill_off"}, 32'(bus.illegal), 0);
    end

    // backpressure holds the slot
    @(negedge clk);
    drive(va); bus.in_valid = 1; bus.out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    drive(vb); bus.out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp.rdy", 32'(bus.in_ready), 0);
      @(posedge clk); #1;
      chk("bp.valid", 32'(bus.out_valid), 1);
      check_slot("bp.hold", 6'h08, 7, 9, 5);
      @(negedge clk);
    end
    bus.out_ready = 1;
    #1 chk("bp.rdy1", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    chk("bp.valid1", 32'(bus.out_valid), 1);
    check_slot("bp.next", 6'h08, 100, 3, 2);
    @(negedge clk);
    bus.in_valid = 0;
    @(posedge clk); #1;
    chk("bp.drain", 32'(bus.out_valid), 0);

    // flush while full blocks the incoming word
    @(negedge clk);
    drive(va); bus.in_valid = 1; bus.out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    drive(vb); bus.out_ready = 0; bus.alu_error = 1;
    #1 chk("fl.rdy", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("fl.valid", 32'(bus.out_valid), 0);
    check_slot("fl.zero", 0, 0, 0, 0);
    @(negedge clk);
    bus.alu_error = 0; bus.out_ready = 1;
    #1 chk("fl.rdy1", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    chk("fl.valid1", 32'(bus.out_valid), 1);
    check_slot("fl.reissue", 6'h08, 100, 3, 2);
    @(negedge clk);
    bus.in_valid = 0;
    @(posedge clk);

    // async reset mid-operation
    @(negedge clk);
    drive(tbl[8]); bus.in_valid = 1; bus.out_ready = 0;
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("ar.valid", 32'(bus.out_valid), 0);
    chk("ar.ill", 32'(bus.illegal), 0);
    check_slot("ar", 0, 0, 0, 0);
    @(negedge clk);
    bus.in_valid = 0; rst = 0;
    @(posedge clk); #1;
    chk("ar.gone", 32'(bus.out_valid), 0);
    chk("ar.rdy", 32'(bus.in_ready), 1);

    // random traffic against the model
    model_clear();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] w;
      logic exp_rdy;
      @(negedge clk);
      w = rand_inst();
      bus.inst      = w;
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.alu_error = ($urandom_range(0, 19) == 0);
      bus.ra_data   = $urandom;
      bus.rb_data   = $urandom;
      bus.wb_en     = $urandom_range(0, 1) == 1;
      bus.wb_data   = $urandom;
      case ($urandom_range(0, 3))
        0, 1:    bus.wb_addr = w[25:21];
        2:       bus.wb_addr = w[20:16];
        default: bus.wb_addr = 5'($urandom);
      endcase
      exp_rdy = (!m_v || bus.out_ready) && !bus.alu_error;
      #1 chk("rnd.rdy", 32'(bus.in_ready), 32'(exp_rdy));
      @(posedge clk);
      model_edge();
      #1;
      chk("rnd.valid", 32'(bus.out_valid), 32'(m_v));
      chk("rnd.ill", 32'(bus.illegal), 32'(m_ill));
      check_slot("rnd", m_op, m_d0, m_d1, m_dst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
